// File: rtl/arb_pkg.sv
// ============================================================
// arb_pkg : shared sizes, state type and round-robin pick
// Revision: 1.0
// ============================================================
`default_nettype none

package arb_pkg;

  localparam int NREQ   = 4;
  localparam int IDX_W  = 2;
  localparam int HCNT_W = 4;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scanned from the far end so the last hit is the first index in search order.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder2_4.sv
// ============================================================
// decoder2_4 : 2-to-4 one-hot decoder
// Revision: 1.0
// ============================================================
`default_nettype none

module decoder2_4 (
  input  logic [1:0] i,
  output logic [3:0] d
);

  assign d = 4'b0001 << i;

endmodule

`default_nettype wire

// File: rtl/rr_arb4.sv
// ============================================================
// rr_arb4 : four-requester round-robin arbiter with bounded hold
// Revision: 1.0
// ============================================================
`default_nettype none

module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  output logic                 gnt_vld,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [HCNT_W-1:0]    hold_cnt
);

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);
  localparam logic [HCNT_W-1:0] HOLD_SAT  = {HCNT_W{1'b1}};

  arb_state_t        state, nxt_state;
  logic [IDX_W-1:0]  ptr, nxt_ptr;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_vld;
  logic [HCNT_W-1:0] nxt_hold;

  logic [IDX_W-1:0]  succ;
  logic [NREQ-1:0]   others;
  logic [NREQ-1:0]   dec;
  pick_t             pick_idle, pick_next, pick_rot;

  assign succ      = gnt_idx + IDX_W'(1);
  assign others    = req & ~(NREQ'(1) << gnt_idx);
  assign pick_idle = rr_pick(req, ptr);
  assign pick_next = rr_pick(req, succ);
  assign pick_rot  = rr_pick(others, succ);

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_vld   = gnt_vld;
    nxt_idx   = gnt_idx;
    nxt_hold  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_idle.found) begin
          nxt_state = BUSY;
          nxt_vld   = 1'b1;
          nxt_idx   = pick_idle.idx;
          nxt_hold  = '0;
        end
      end
      BUSY: begin
        if (!req[gnt_idx]) begin
          // Owner bit is already clear in req, so the pick cannot return it.
          nxt_ptr = succ;
          if (pick_next.found) begin
            nxt_idx  = pick_next.idx;
            nxt_hold = '0;
          end else begin
            nxt_state = IDLE;
            nxt_vld   = 1'b0;
          end
        end else if ((hold_cnt >= HOLD_LAST) && (others != '0)) begin
          // >= so an owner that ran long while alone still yields once contended.
          nxt_ptr  = succ;
          nxt_idx  = pick_rot.idx;
          nxt_hold = '0;
        end else if (hold_cnt != HOLD_SAT) begin
          nxt_hold = hold_cnt + HCNT_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_vld  <= 1'b0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      gnt_vld  <= nxt_vld;
      gnt_idx  <= nxt_idx;
      hold_cnt <= nxt_hold;
    end
  end

  decoder2_4 u_dec (
    .i (gnt_idx),
    .d (dec)
  );

  assign gnt = dec & {NREQ{gnt_vld}};

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4.sv
// ============================================================
// tb_rr_arb4 : directed and random checks of rr_arb4 against a reference model
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_rr_arb4;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic [3:0] gnt;
  logic [3:0] hold_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_vld;
  int m_idx;
  int m_hold;
  int m_ptr;

  rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx),
    .gnt      (gnt),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_idx = 0; m_hold = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int p;
    logic [3:0] rest;
    if (!m_vld) begin
      p = first_from(r, m_ptr);
      if (p >= 0) begin m_vld = 1; m_idx = p; m_hold = 0; end
    end else if (!r[m_idx]) begin
      m_ptr = (m_idx + 1) % 4;
      p = first_from(r, m_ptr);
      if (p >= 0) begin m_idx = p; m_hold = 0; end
      else m_vld = 0;
    end else begin
      rest = r;
      rest[m_idx] = 1'b0;
      if (m_hold >= MAX_HOLD - 1 && rest != 4'b0000) begin
        m_ptr  = (m_idx + 1) % 4;
        m_idx  = first_from(rest, m_ptr);
        m_hold = 0;
      end else if (m_hold < 15) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = m_vld ? (4'b0001 << m_idx) : 4'b0000;
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(m_vld));
    chk({tag, ".hold"}, 32'(hold_cnt), 32'(m_hold));
    if (m_vld) chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
  endtask

  // Apply req for one edge, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset.gnt", 32'(gnt), 32'h0);
    chk("reset.vld", 32'(gnt_vld), 32'h0);
    chk("reset.idx", 32'(gnt_idx), 32'h0);
    chk("reset.hold", 32'(hold_cnt), 32'h0);
  endtask

  initial begin
    logic [3:0] r;

    // Single request held three cycles, then dropped
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(4'b0010, "single");
      chk("single.gnt_const", 32'(gnt), 32'h2);
    end
    step(4'b0000, "single_drop");
    chk("single_drop.gnt_const", 32'(gnt), 32'h0);

    // Full contention: four cycles per owner, rotating 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(4'b1111, "contend");
      chk("contend.gnt_const", 32'(gnt), 32'(4'b0001 << ((k / 4) % 4)));
      chk("contend.hold_const", 32'(hold_cnt), 32'(k % 4));
    end

    // Back-to-back handoff with no idle bubble
    do_reset();
    step(4'b0101, "handoff_a");
    chk("handoff_a.gnt_const", 32'(gnt), 32'h1);
    step(4'b0100, "handoff_b");
    chk("handoff_b.gnt_const", 32'(gnt), 32'h4);

    // Lone hog is never preempted; hold count saturates
    do_reset();
    for (int k = 0; k < 20; k++) step(4'b1000, "hog");
    chk("hog.gnt_const", 32'(gnt), 32'h8);
    chk("hog.hold_sat", 32'(hold_cnt), 32'd15);

    // Priority wrap: owner 2 releases, pointer moves to 3, 0 wins over 1
    do_reset();
    step(4'b0100, "wrap_own2");
    step(4'b0000, "wrap_rel");
    step(4'b0011, "wrap_pick");
    chk("wrap.gnt_const", 32'(gnt), 32'h1);

    // Asynchronous reset between edges while index 2 holds the grant
    do_reset();
    step(4'b0100, "areset_pre");
    chk("areset_pre.gnt_const", 32'(gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("areset.gnt_now", 32'(gnt), 32'h0);
    chk("areset.vld_now", 32'(gnt_vld), 32'h0);
    #1 rst = 1'b0;
    model_reset();
    step(4'b0110, "areset_post");
    chk("areset_post.gnt_const", 32'(gnt), 32'h2);

    // Random traffic; requests tend to persist so holds and rotations occur
    do_reset();
    r = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
      step(r, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
